e_mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the E stage of the pipelined CPU. It sits beside E_ALU and accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the E-stage control word. It owns the HI/LO registers and sequences the fixed-latency busy window. It also raises the stall request that the hazard unit uses to freeze D while the MDU is occupied.

---
 rtl/e_mdu_ctrl_pkg.sv | 37 +++
 rtl/e_mdu_arith.sv | 51 +++++
 rtl/e_mdu_ctrl.sv | 107 ++++++++++
 tb/tb_e_mdu_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU definitions: op codes, FSM states, default latencies
// and op classification helpers.
package e_mdu_ctrl_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t MDU_NONE  = 4'd0;
    localparam mdu_op_t MDU_MULT  = 4'd1;
    localparam mdu_op_t MDU_MULTU = 4'd2;
    localparam mdu_op_t MDU_DIV   = 4'd3;
    localparam mdu_op_t MDU_DIVU  = 4'd4;
    localparam mdu_op_t MDU_MFHI  = 4'd5;
    localparam mdu_op_t MDU_MFLO  = 4'd6;
    localparam mdu_op_t MDU_MTHI  = 4'd7;
    localparam mdu_op_t MDU_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic logic mdu_is_mul(mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic mdu_is_div(mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_start(mdu_op_t op);
        return mdu_is_mul(op) || mdu_is_div(op);
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational datapath for the MDU: 64-bit product or
// {remainder, quotient}, plus a divide-by-zero flag.
module e_mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        is_sgn;
    logic        is_div;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign is_sgn = (op == MDU_MULT) || (op == MDU_DIV);
    assign is_div = mdu_is_div(op);

    // Sign-extending to 64 bits lets one unsigned multiplier serve both forms.
    assign ext_a = {{32{is_sgn & a[31]}}, a};
    assign ext_b = {{32{is_sgn & b[31]}}, b};
    assign prod  = ext_a * ext_b;

    assign a_neg  = is_sgn & a[31];
    assign b_neg  = is_sgn & b[31];
    assign a_mag  = a_neg ? (32'd0 - a) : a;
    assign b_mag  = b_neg ? (32'd0 - b) : b;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;

    // Magnitude division: quotient truncates to zero, remainder follows dividend.
    assign quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem = a_neg ? (32'd0 - r_mag) : r_mag;

    assign result   = is_div ? {rem, quo} : prod;
    assign div_zero = is_div && (b == 32'd0);

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, sequences the
// fixed-latency busy window and raises the stall request.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_mdu_op,
    input  logic [31:0] E_data1,
    input  logic [31:0] E_data2,
    output logic [31:0] E_mdu_out,
    output logic        E_busy,
    output logic        E_stall
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_LOG = $clog2(CNT_MAX + 1);
    localparam int CNT_W   = (CNT_LOG > 4) ? CNT_LOG : 4;

    mdu_state_e       state;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      hi_nxt;
    logic [31:0]      lo_nxt;
    logic             start;
    logic             commit;
    logic [63:0]      res;
    logic             dz;

    e_mdu_arith u_arith (
        .op       (E_mdu_op),
        .a        (E_data1),
        .b        (E_data2),
        .result   (res),
        .div_zero (dz)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        start   = 1'b0;
        commit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mdu_is_start(E_mdu_op)) begin
                    start   = 1'b1;
                    state_d = ST_BUSY;
                    cnt_d   = mdu_is_mul(E_mdu_op) ? CNT_W'(MULT_CYCLES)
                                                   : CNT_W'(DIV_CYCLES);
                end
            end
            ST_BUSY: begin
                cnt_d = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_nxt <= '0;
            lo_nxt <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            // A zero divisor re-latches the live HI/LO so commit is a no-op.
            if (start) begin
                hi_nxt <= dz ? hi : res[63:32];
                lo_nxt <= dz ? lo : res[31:0];
            end
            if (commit) begin
                hi <= hi_nxt;
                lo <= lo_nxt;
            end else if (state == ST_IDLE) begin
                if (E_mdu_op == MDU_MTHI) hi <= E_data1;
                if (E_mdu_op == MDU_MTLO) lo <= E_data1;
            end
        end
    end

    always_comb begin
        E_mdu_out = '0;
        unique case (1'b1)
            (E_mdu_op == MDU_MFHI): E_mdu_out = hi;
            (E_mdu_op == MDU_MFLO): E_mdu_out = lo;
            default:                E_mdu_out = '0;
        endcase
    end

    assign E_busy  = (state == ST_BUSY);
    assign E_stall = E_busy | mdu_is_start(E_mdu_op);

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: behavioural HI/LO model
// compared every cycle, plus directed literal checks.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_mdu_op;
    logic [31:0] E_data1;
    logic [31:0] E_data2;
    logic [31:0] E_mdu_out;
    logic        E_busy;
    logic        E_stall;

    int n_chk  = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int busy_cnt  = 0;

    // behavioural model state
    int          m_left = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [31:0] m_phi  = '0;
    logic [31:0] m_plo  = '0;

    e_mdu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .E_mdu_op  (E_mdu_op),
        .E_data1   (E_data1),
        .E_data2   (E_data2),
        .E_mdu_out (E_mdu_out),
        .E_busy    (E_busy),
        .E_stall   (E_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_start_op(logic [3:0] op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction

    // Model: compute result with plain arithmetic, deliver after N cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else begin
            longint sa, sb, p;
            logic [63:0] up;
            sa = longint'($signed(E_data1));
            sb = longint'($signed(E_data2));
            case (E_mdu_op)
                MDU_MULT: begin
                    p = sa * sb;
                    m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5;
                end
                MDU_MULTU: begin
                    up = {32'd0, E_data1} * {32'd0, E_data2};
                    m_phi = up[63:32]; m_plo = up[31:0]; m_left = 5;
                end
                MDU_DIV: begin
                    if (E_data2 == 0) begin
                        m_phi = m_hi; m_plo = m_lo;
                    end else begin
                        longint q, r;
                        q = sa / sb;
                        r = sa % sb;
                        m_plo = q[31:0]; m_phi = r[31:0];
                    end
                    m_left = 10;
                end
                MDU_DIVU: begin
                    if (E_data2 == 0) begin
                        m_phi = m_hi; m_plo = m_lo;
                    end else begin
                        m_plo = E_data1 / E_data2;
                        m_phi = E_data1 % E_data2;
                    end
                    m_left = 10;
                end
                MDU_MTHI: m_hi = E_data1;
                MDU_MTLO: m_lo = E_data1;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [31:0] m_out;
        m_out = (E_mdu_op == MDU_MFHI) ? m_hi :
                (E_mdu_op == MDU_MFLO) ? m_lo : 32'd0;
        chk("busy", {31'd0, E_busy}, {31'd0, m_left > 0});
        chk("stall", {31'd0, E_stall},
            {31'd0, (m_left > 0) || is_start_op(E_mdu_op)});
        chk("out", E_mdu_out, m_out);
        if (E_stall) stall_cnt++;
        if (E_busy)  busy_cnt++;
    end

    task automatic step(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        E_mdu_op = op;
        E_data1  = a;
        E_data2  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(MDU_NONE, 32'd0, 32'd0);
    endtask

    task automatic peek(logic [3:0] op, logic [31:0] exp, string name);
        E_mdu_op = op;
        #1;
        chk(name, E_mdu_out, exp);
    endtask

    task automatic clr();
        stall_cnt = 0;
        busy_cnt  = 0;
    endtask

    initial begin
        reset = 1'b0;
        E_mdu_op = MDU_NONE;
        E_data1 = '0;
        E_data2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        chk("rst_busy", {31'd0, E_busy}, 32'd0);
        chk("rst_stall", {31'd0, E_stall}, 32'd0);
        peek(MDU_NONE, 32'd0, "rst_out");
        peek(MDU_MFHI, 32'd0, "rst_hi");

        clr();
        step(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        idle(8);
        chk("mult_stall_len", stall_cnt, 6);
        chk("mult_busy_len", busy_cnt, 5);
        peek(MDU_MFHI, 32'hFFFF_FFFF, "mult_hi");
        peek(MDU_MFLO, 32'hFFFF_FFFE, "mult_lo");

        step(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        idle(8);
        peek(MDU_MFHI, 32'h0000_0001, "multu_hi");
        peek(MDU_MFLO, 32'hFFFF_FFFE, "multu_lo");

        clr();
        step(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        idle(12);
        chk("div_busy_len", busy_cnt, 10);
        chk("div_stall_len", stall_cnt, 11);
        peek(MDU_MFLO, 32'hFFFF_FFFD, "div_lo");
        peek(MDU_MFHI, 32'hFFFF_FFFF, "div_hi");

        step(MDU_DIVU, 32'd7, 32'd2);
        idle(12);
        peek(MDU_MFLO, 32'd3, "divu_lo");
        peek(MDU_MFHI, 32'd1, "divu_hi");

        step(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(12);
        peek(MDU_MFLO, 32'h8000_0000, "divovf_lo");
        peek(MDU_MFHI, 32'd0, "divovf_hi");

        step(MDU_MTHI, 32'h1234_5678, 32'd0);
        clr();
        step(MDU_DIVU, 32'd5, 32'd0);
        idle(12);
        chk("div0_busy_len", busy_cnt, 10);
        peek(MDU_MFHI, 32'h1234_5678, "div0_hi");
        peek(MDU_MFLO, 32'h8000_0000, "div0_lo");

        clr();
        step(MDU_MULT, 32'd3, 32'd4);
        step(MDU_NONE, 32'd0, 32'd0);
        step(MDU_MULT, 32'd5, 32'd6);
        step(MDU_MTLO, 32'h0000_AAAA, 32'd0);
        idle(6);
        chk("ign_busy_len", busy_cnt, 5);
        peek(MDU_MFLO, 32'd12, "ign_lo");
        peek(MDU_MFHI, 32'd0, "ign_hi");

        step(MDU_DIV, 32'd100, 32'd7);
        idle(2);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, E_busy}, 32'd0);
        peek(MDU_MFHI, 32'd0, "abort_hi");
        peek(MDU_MFLO, 32'd0, "abort_lo");
        @(posedge clk);
        #1 reset = 1'b1;
        peek(MDU_MFLO, 32'd0, "post_rst_lo");
        idle(1);

        step(MDU_MTLO, 32'hDEAD_BEEF, 32'd0);
        peek(MDU_MFLO, 32'hDEAD_BEEF, "mtlo_lo");
        peek(MDU_NONE, 32'd0, "none_out");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
